receiver_axis_fifo: RTL and testbench
=====================================

Name: receiver_axis_fifo

Overview:
- Parametrised UART receiver with AXI4-Stream master output and an internal FIFO.
- Adds configurable word width, parity and stop bits, mid-bit sampling, an input synchronizer, per-word error flags and overflow reporting.
- Sits between the external RX pin and any AXIS consumer. Absorbs consumer backpressure of up to FIFO_DEPTH words without losing data.

Parameters:
- CLOCK_FREQUENCY, 100_000_000, clk frequency in Hz
- BAUD_RATE, 115200, line rate in bit/s
- WORD_WIDTH, 8, data bits per frame (legal 5..9)
- PARITY, 0, 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1, stop bits per frame (1 or 2)
- FIFO_DEPTH, 16, output FIFO entries (power of 2, >=2)

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- din  input  1  asynchronous UART RX line, idle high
- dout_axis_tdata  output  WORD_WIDTH  received word, LSB = first data bit
- dout_axis_tuser  output  2  [1] = parity_err, [0] = frame_err for this word
- dout_axis_tvalid  output  1  FIFO non-empty
- dout_axis_tready  input  1  consumer ready
- overflow  output  1  one-cycle pulse when a completed word is dropped because the FIFO is full
- fill_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset: asynchronous on rst_n low.
  - state = IDLE, FIFO empty.
  - tvalid = 0, tdata = 0, tuser = 0, overflow = 0, fill_level = 0.
  - Both synchronizer flops = 1, so no false start edge after reset.
  - Reset mid-frame discards the partial word.
- Timing constants:
  - BIT_CYCLES = CLOCK_FREQUENCY/BAUD_RATE (integer division; 868 at defaults).
  - HALF = BIT_CYCLES/2.
  - Elaboration error if BIT_CYCLES < 4.
- Input: din passes through a 2-flop synchronizer; all decisions use the synchronized value rxs.
- State machine:
  - IDLE: requires rxs = 1 for at least 1 cycle (armed). Falling edge of rxs while armed -> START, counter = 0.
  - START: at counter = HALF-1, sample rxs.
    - 1 -> glitch, return to IDLE, nothing pushed.
    - 0 -> DATA, counter = 0, bit index = 0.
  - DATA: sample at every counter = BIT_CYCLES-1, shifting LSB first. After WORD_WIDTH samples -> PARITY if PARITY != 0, else STOP.
  - PARITY: one sample. parity_err = 1 if XOR(data, sample) != (PARITY == 1 ? 1 : 0).
  - STOP: STOP_BITS samples at bit centres. Any sample = 0 sets frame_err. After the last stop sample -> PUSH.
  - PUSH: one cycle. Writes {tuser, tdata} into the FIFO, then -> IDLE.
    - IDLE disarms until rxs = 1 is seen, so a break (line held low) yields exactly one frame_err word, not a stream of them.
- Errored words are still pushed, with their flags set. The receiver never stalls on tready.
- Latency: last stop sample in cycle T, PUSH in T+1. If the FIFO was empty, tvalid = 1 with valid tdata/tuser in T+2.
- FIFO behaviour:
  - First-word fall-through. tvalid = !empty.
  - tdata/tuser are held stable while tvalid && !tready.
  - Pop when tvalid && tready.
  - Push with FIFO full and no pop in the same cycle: word dropped, overflow = 1 for exactly that cycle, FIFO contents unchanged.
  - Push and pop in the same cycle while full: both succeed, fill_level unchanged, no overflow.
  - Push and pop in the same cycle while empty: the pop is not possible (tvalid = 0); the push lands normally.
  - Pointers wrap modulo FIFO_DEPTH.
  - fill_level updates one cycle after the push/pop edge.
- Back-to-back frames: the next start edge may arrive anywhere from the cycle after PUSH onward; no inter-frame gap is required beyond the stop bit(s).

Decomposition:
- Package receiver_axis_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP, PUSH).
  - parity mode constants PARITY_NONE/ODD/EVEN.
  - function bit_cycles(freq, baud).
  - tuser bit index constants.
- One sub-module, axis_sync_fifo:
  - Parameters: WIDTH, DEPTH.
  - Async active-low reset, FWFT, full/empty/level outputs.
  - Instantiated with WIDTH = WORD_WIDTH+2.

Test Plan:
- Defaults, tready = 1, send 0xA5 (8N1, 868 cycles/bit) -> tvalid at T+2, tdata = 0xA5, tuser = 00, tvalid low the next cycle.
- PARITY = 2, WORD_WIDTH = 7, send 0x55 with parity bit 1 -> tuser = 10; resend with the correct parity bit 0 -> tuser = 00.
- STOP_BITS = 2, second stop bit driven 0 -> word pushed with tuser = 01; hold din low 20 bit times -> exactly one word total, next valid frame 0x3C received cleanly.
- 100-cycle low glitch on idle din -> no push, state back to IDLE, tvalid stays 0.
- tready = 0, send 17 words 0x00..0x10 with FIFO_DEPTH = 16 -> fill_level = 16, one overflow pulse on the 17th; then tready = 1 -> drains 0x00..0x0F in order.
- Assert rst_n low mid-DATA with 3 words queued -> tvalid = 0 and fill_level = 0 immediately; after release, 0x81 is received correctly with no spurious word.

Source files
------------

// File: rtl/receiver_axis_pkg.sv
// Shared types and constants for the AXI4-Stream UART receiver.
// Holds the receiver state encoding, parity modes and tuser bit positions.
package receiver_axis_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_PUSH
  } state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  localparam int TUSER_FRAME_ERR  = 0;
  localparam int TUSER_PARITY_ERR = 1;

  function automatic int bit_cycles(input longint freq, input longint baud);
    return int'(freq / baud);
  endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy reporting.
// Push while full without a simultaneous pop is ignored; the caller reports the drop.
module axis_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_valid,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_ready,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    count_q, count_d;
  logic             do_push, do_pop;
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == LW'(DEPTH));
    do_pop   = rd_ready && !empty;
    do_push  = wr_valid && (!full || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // Empty FIFO presents zeros rather than stale storage.
    rd_data = empty ? '0 : mem_q[rd_ptr_q];
    level   = count_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage has no reset; validity is tracked by the pointers and count alone.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/receiver_axis_fifo.sv
// UART receiver with mid-bit sampling, parity/stop checking and a FWFT
// AXI4-Stream output FIFO carrying per-word error flags in tuser.
module receiver_axis_fifo
  import receiver_axis_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE       = 115200,
  parameter int WORD_WIDTH      = 8,
  parameter int PARITY          = 0,
  parameter int STOP_BITS       = 1,
  parameter int FIFO_DEPTH      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          din,
  output logic [WORD_WIDTH-1:0]         dout_axis_tdata,
  output logic [1:0]                    dout_axis_tuser,
  output logic                          dout_axis_tvalid,
  input  logic                          dout_axis_tready,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level
);

  localparam int BIT_CYCLES = bit_cycles(CLOCK_FREQUENCY, BAUD_RATE);
  localparam int HALF       = BIT_CYCLES / 2;
  localparam int CNT_W      = $clog2(BIT_CYCLES);
  localparam int IDX_W      = $clog2(WORD_WIDTH);
  localparam int FW         = WORD_WIDTH + 2;

  localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [IDX_W-1:0] IDX_WORD_LAST = IDX_W'(WORD_WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_STOP_LAST = IDX_W'(STOP_BITS - 1);
  localparam logic             PARITY_TARGET = (PARITY == PARITY_ODD);

  if (BIT_CYCLES < 4) begin : g_bad_baud
    $error("receiver_axis_fifo: CLOCK_FREQUENCY/BAUD_RATE must be at least 4");
  end
  if (WORD_WIDTH < 5 || WORD_WIDTH > 9) begin : g_bad_width
    $error("receiver_axis_fifo: WORD_WIDTH must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("receiver_axis_fifo: STOP_BITS must be 1 or 2");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("receiver_axis_fifo: PARITY must be 0, 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("receiver_axis_fifo: FIFO_DEPTH must be a power of 2 and >= 2");
  end

  logic                  sync1_q, sync2_q, rxs;
  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [WORD_WIDTH-1:0] shift_q, shift_d;
  logic                  perr_q, perr_d;
  logic                  ferr_q, ferr_d;
  logic                  armed_q, armed_d;
  logic                  push, bit_done;
  logic [1:0]            tuser_w;
  logic [FW-1:0]         fifo_rdata;
  logic                  fifo_full, fifo_empty;

  // Synchronizer resets to idle-high so release of reset is never seen as a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make each flop sample the pre-edge value of the one before it.
      sync1_q <= din;
      sync2_q <= sync1_q;
    end
  end
  assign rxs = sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      armed_q <= armed_d;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    perr_d   = perr_q;
    ferr_d   = ferr_q;
    armed_d  = rxs;
    push     = 1'b0;
    bit_done = (cnt_q == CNT_BIT_LAST);

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        // armed_q is last cycle's rxs, so a held-low line never re-triggers.
        if (armed_q && !rxs) begin
          state_d = ST_START;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      ST_START: begin
        if (cnt_q == CNT_HALF_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rxs ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          cnt_d   = '0;
          shift_d = {rxs, shift_q[WORD_WIDTH-1:1]};
          idx_d   = idx_q + 1'b1;
          if (idx_q == IDX_WORD_LAST) begin
            idx_d   = '0;
            state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_PARITY: begin
        if (bit_done) begin
          cnt_d   = '0;
          perr_d  = ((^shift_q) ^ rxs) != PARITY_TARGET;
          state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          cnt_d = '0;
          idx_d = idx_q + 1'b1;
          if (!rxs) ferr_d = 1'b1;
          if (idx_q == IDX_STOP_LAST) state_d = ST_PUSH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_PUSH: begin
        push    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tuser_w                   = '0;
    tuser_w[TUSER_PARITY_ERR] = perr_q;
    tuser_w[TUSER_FRAME_ERR]  = ferr_q;
  end

  axis_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (push),
    .wr_data  ({tuser_w, shift_q}),
    .rd_ready (dout_axis_tready),
    .rd_data  (fifo_rdata),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fill_level)
  );

  assign dout_axis_tvalid = !fifo_empty;
  assign dout_axis_tdata  = fifo_rdata[WORD_WIDTH-1:0];
  assign dout_axis_tuser  = fifo_rdata[FW-1:WORD_WIDTH];
  assign overflow         = push && fifo_full && !(dout_axis_tvalid && dout_axis_tready);

endmodule

// File: tb/tb_receiver_axis_fifo.sv
// Self-checking bench for receiver_axis_fifo: directed and randomized UART frames
// checked against a queue-based reference of the frame rules.
module tb_receiver_axis_fifo;

  localparam int CLK_F  = 1_600_000;
  localparam int BAUD   = 100_000;
  localparam int W      = 8;
  localparam int PAR    = 2;
  localparam int SB     = 2;
  localparam int DEPTH  = 16;
  localparam int B      = CLK_F / BAUD;
  localparam int HALF   = B / 2;
  localparam int NSAMP  = W + ((PAR != 0) ? 1 : 0) + SB;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         din;
  logic [W-1:0] tdata;
  logic [1:0]   tuser;
  logic         tvalid;
  logic         tready;
  logic         overflow;
  logic [4:0]   fill_level;

  int checks = 0;
  int errors = 0;
  int pops = 0;
  int ovf_cycles = 0;
  int exp_drops = 0;
  logic [W+1:0] exp_q [$];

  always #5 clk = ~clk;

  receiver_axis_fifo #(
    .CLOCK_FREQUENCY (CLK_F),
    .BAUD_RATE       (BAUD),
    .WORD_WIDTH      (W),
    .PARITY          (PAR),
    .STOP_BITS       (SB),
    .FIFO_DEPTH      (DEPTH)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .din              (din),
    .dout_axis_tdata  (tdata),
    .dout_axis_tuser  (tuser),
    .dout_axis_tvalid (tvalid),
    .dout_axis_tready (tready),
    .overflow         (overflow),
    .fill_level       (fill_level)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Consumer side: every accepted beat must match the oldest expected word.
  always @(negedge clk) begin
    if (overflow) ovf_cycles++;
    if (rst_n && tvalid && tready) begin
      if (exp_q.size() == 0) begin
        check("spurious_word", 32'd1, 32'd0);
      end else begin
        check("tdata", 32'(tdata), 32'(exp_q[0][W-1:0]));
        check("tuser", 32'(tuser), 32'(exp_q[0][W+1:W]));
        void'(exp_q.pop_front());
      end
      pops++;
    end
  end

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 tready = v;
  endtask

  // Drives one frame on din and records what the receiver must deliver.
  task automatic send_frame(input logic [W-1:0] data, input bit flip_par, input logic [SB-1:0] stops);
    int   ones;
    logic pbit;
    logic perr;
    logic ferr;
    ones = $countones(data);
    if (PAR == 2) pbit = logic'(ones % 2);
    else          pbit = logic'((ones + 1) % 2);
    pbit = pbit ^ flip_par;
    if (PAR == 0)      perr = 1'b0;
    else if (PAR == 2) perr = ((ones + int'(pbit)) % 2) != 0;
    else               perr = ((ones + int'(pbit)) % 2) == 0;
    ferr = !(&stops);
    if (exp_q.size() >= DEPTH) exp_drops++;
    else exp_q.push_back({perr, ferr, data});

    @(negedge clk);
    din = 1'b0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < W; i++) begin
      din = data[i];
      repeat (B) @(negedge clk);
    end
    if (PAR != 0) begin
      din = pbit;
      repeat (B) @(negedge clk);
    end
    for (int i = 0; i < SB; i++) begin
      din = stops[i];
      repeat (B) @(negedge clk);
    end
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 12 * 20 * B) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check({tag, "_drained"}, exp_q.size(), 0);
    check({tag, "_fill0"}, 32'(fill_level), 0);
  endtask

  initial begin
    int p0;
    int o0;
    din    = 1'b1;
    tready = 1'b0;
    rst_n  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tvalid", 32'(tvalid), 0);
    check("rst_tdata", 32'(tdata), 0);
    check("rst_tuser", 32'(tuser), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_fill", 32'(fill_level), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // First word latency: last stop sample T, word visible at T+2, popped next cycle.
    set_ready(1'b1);
    fork
      send_frame(8'hA5, 1'b0, 2'b11);
      begin
        int k = 0;
        @(negedge clk);
        do begin
          @(posedge clk);
          #1 k++;
        end while (!tvalid && k < 400);
        check("latency_cycles", k, 4 + HALF + NSAMP * B);
        check("latency_tvalid", 32'(tvalid), 1);
        check("latency_tdata", 32'(tdata), 32'h0A5);
        @(posedge clk);
        #1 check("tvalid_after_pop", 32'(tvalid), 0);
      end
    join
    wait_drain("a5");

    // Parity error, then the same word with the correct parity bit.
    send_frame(8'h55, 1'b1, 2'b11);
    send_frame(8'h55, 1'b0, 2'b11);
    wait_drain("parity");

    // Bad second stop bit followed by a long break: exactly one word.
    p0 = pops;
    send_frame(8'hC3, 1'b0, 2'b01);
    repeat (20 * B) @(negedge clk);
    din = 1'b1;
    repeat (2 * B) @(negedge clk);
    wait_drain("break");
    check("break_one_word", pops - p0, 1);
    send_frame(8'h3C, 1'b0, 2'b11);
    wait_drain("after_break");
    check("after_break_words", pops - p0, 2);

    // Short low glitch on idle line is rejected by the start-bit check.
    p0 = pops;
    @(negedge clk);
    din = 1'b0;
    repeat (HALF / 2) @(negedge clk);
    din = 1'b1;
    repeat ((NSAMP + 2) * B) @(negedge clk);
    check("glitch_no_word", pops - p0, 0);
    check("glitch_tvalid", 32'(tvalid), 0);
    check("glitch_fill", 32'(fill_level), 0);
    send_frame(8'h42, 1'b0, 2'b11);
    wait_drain("post_glitch");
    check("post_glitch_word", pops - p0, 1);

    // Fill to DEPTH with the consumer stalled, then one more word is dropped.
    set_ready(1'b0);
    o0 = ovf_cycles;
    for (int i = 0; i <= DEPTH; i++) send_frame(8'(i), 1'b0, 2'b11);
    repeat (B) @(negedge clk);
    check("full_fill", 32'(fill_level), DEPTH);
    check("overflow_pulse_cycles", ovf_cycles - o0, 1);
    check("model_drops", exp_drops, 1);
    check("hold_tdata", 32'(tdata), 32'(exp_q[0][W-1:0]));
    repeat (50) @(negedge clk);
    check("hold_tdata_late", 32'(tdata), 32'(exp_q[0][W-1:0]));
    check("hold_tvalid", 32'(tvalid), 1);
    set_ready(1'b1);
    wait_drain("overflow");

    // Randomized frames with random stalls, parity and first-stop errors.
    for (int i = 0; i < 12; i++) begin
      logic [W-1:0] d;
      bit           fp;
      logic         bad_stop;
      set_ready(logic'($urandom_range(0, 1)));
      d        = W'($urandom);
      fp       = ($urandom_range(0, 3) == 0);
      bad_stop = ($urandom_range(0, 3) == 0);
      send_frame(d, fp, {1'b1, ~bad_stop});
      repeat ($urandom_range(0, 10)) @(negedge clk);
    end
    set_ready(1'b1);
    wait_drain("random");

    // Reset during DATA with words queued clears everything immediately.
    set_ready(1'b0);
    send_frame(8'h11, 1'b0, 2'b11);
    send_frame(8'h22, 1'b0, 2'b11);
    send_frame(8'h33, 1'b0, 2'b11);
    repeat (4) @(negedge clk);
    check("pre_reset_fill", 32'(fill_level), 3);
    din = 1'b0;
    repeat (B) @(negedge clk);
    din = 1'b1;
    repeat (2 * B) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_tvalid", 32'(tvalid), 0);
    check("midreset_fill", 32'(fill_level), 0);
    check("midreset_tdata", 32'(tdata), 0);
    exp_q.delete();
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    p0 = pops;
    set_ready(1'b1);
    repeat (3 * B) @(negedge clk);
    check("post_reset_no_word", pops - p0, 0);
    send_frame(8'h81, 1'b0, 2'b11);
    wait_drain("post_reset");
    check("post_reset_word", pops - p0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
